mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 8-bit storage words (addresses 0..DEPTH-1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, response buffer capacity including the pipeline stage.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  5  word address.
REQ-009 SHALL have port req_wdata  input  8  write data.
REQ-010 SHALL have port rsp_valid  output  1  response at buffer head is valid.
REQ-011 SHALL have port rsp_ready  input  1  initiator accepts the response.
REQ-012 SHALL have port rsp_rdata  output  8  read data or echoed write data.
REQ-013 SHALL have port rsp_we  output  1  echo of req_we for this response.
REQ-014 SHALL have port rsp_err  output  1  request addressed outside 0..DEPTH-1.
REQ-015 SHALL have port err_count  output  8  saturating count of error responses issued.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; there is exactly one response per accepted request, in acceptance order.
REQ-017 req_ready SHALL be 1 iff (stage occupancy + buffer count) < FIFO_DEPTH, computed from registered state only (no combinational path from rsp_ready).
REQ-018 Valid write (addr < DEPTH): storage[addr] SHALL update on the acceptance edge; response rdata = req_wdata, we=1, err=0.
REQ-019 Valid read: response rdata SHALL be storage[addr] as updated by all previously accepted writes, including a write accepted on the immediately preceding edge; we=0, err=0.
REQ-020 Out-of-range request (addr >= DEPTH): no storage change; response rdata=8'h00, err=1, we echoed.
REQ-021 Latency: request accepted at edge k SHALL enter the one-entry stage at edge k, move to the buffer at edge k+1, and, if the buffer was empty, drive rsp_valid=1 in the cycle after edge k+1.
REQ-022 A response SHALL be popped on a rising edge where rsp_valid=1 and rsp_ready=1; rsp_rdata/rsp_we/rsp_err SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-023 Simultaneous push (stage to buffer) and pop on the same edge SHALL leave count unchanged and preserve order.
REQ-024 With rsp_ready held 1 and req_valid held 1, SHALL sustain one accepted request and one response per cycle after initial latency.
REQ-025 Full: after FIFO_DEPTH accepted requests with rsp_ready=0, req_ready SHALL be 0 and no further request is accepted; req_ready returns to 1 the cycle after the first pop.
REQ-026 Buffer read/write pointers SHALL wrap modulo FIFO_DEPTH with no loss or duplication.
REQ-027 err_count SHALL increment on each popped response with err=1 and saturate at 8'hFF.
REQ-028 rsp_valid SHALL be 0 whenever the buffer is empty.

Reset
REQ-029 While reset=0: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_we=0, rsp_err=0, err_count=0, stage and buffer empty, all storage words 8'h00.
REQ-030 Reset assertion SHALL take effect immediately (asynchronous), discarding in-flight and buffered responses; none SHALL be emitted after release.
REQ-031 req_ready SHALL be 1 in the first cycle after reset deasserts (release synchronised to clk).

Verification
REQ-032 Reset then read addr 3, rsp_ready=1 -> rsp_valid two cycles after req_valid presented, rdata=8'h00, err=0.
REQ-033 Write addr 5 = 8'hA5, next cycle read addr 5 -> responses in order: (we=1, rdata=A5), (we=0, rdata=A5).
REQ-034 rsp_ready=0, issue 6 back-to-back reads -> exactly 4 accepted, req_ready=0; raise rsp_ready -> 4 responses in order, remaining 2 then accepted.
REQ-035 Read addr 20 and write addr 16 = 8'h55 -> both rsp_err=1, rdata=0, storage unchanged, err_count=2 after both popped.
REQ-036 Assert reset with 3 responses buffered -> outputs per REQ-029 immediately, no responses after release, storage cleared.
REQ-037 20 random requests with random rsp_ready toggling -> scoreboard matches order and data; wrap-around exercised at least 3 times.

Source files
------------

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_if
// Description : Request/response handshake bundle between an initiator and
//               the mem_responder storage block.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_we;
  logic       rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Byte-wide register-file responder. Each accepted request
//               passes through a one-entry stage into an in-order response
//               buffer; out-of-range addresses answer with an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  wire             clk,
  input  wire             reset,
  mem_responder_if.slave  bus,
  output logic [7:0]      err_count
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(FIFO_DEPTH - 1);
  localparam logic [c_CW:0]   c_OCC_MAX  = (c_CW + 1)'(FIFO_DEPTH);

  logic [7:0]      r_mem [DEPTH];
  logic            r_run;

  logic            r_stg_vld;
  logic [7:0]      r_stg_data;
  logic            r_stg_we;
  logic            r_stg_err;

  logic [7:0]      r_buf_data [FIFO_DEPTH];
  logic            r_buf_we   [FIFO_DEPTH];
  logic            r_buf_err  [FIFO_DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [7:0]      r_err_count;

  logic            w_in_range;
  logic [c_AW-1:0] w_idx;
  logic [c_CW:0]   w_occupancy;
  logic            w_req_ready;
  logic            w_accept;
  logic            w_rsp_valid;
  logic            w_pop;
  logic            w_push;
  logic [7:0]      w_rsp_data;

  assign w_in_range  = int'(bus.req_addr) < DEPTH;
  assign w_idx       = bus.req_addr[c_AW-1:0];

  // Readiness looks only at flops, so rsp_ready never reaches req_ready.
  assign w_occupancy = {1'b0, r_count} + {{c_CW{1'b0}}, r_stg_vld};
  assign w_req_ready = r_run && (w_occupancy < c_OCC_MAX);
  assign w_accept    = bus.req_valid && w_req_ready;

  assign w_rsp_valid = (r_count != '0);
  assign w_pop       = w_rsp_valid && bus.rsp_ready;
  assign w_push      = r_stg_vld;

  always_comb begin
    w_rsp_data = 8'h00;
    if (w_in_range) begin
      w_rsp_data = bus.req_we ? bus.req_wdata : r_mem[w_idx];
    end
  end

  // Gate that holds req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (w_accept && bus.req_we && w_in_range) begin
      r_mem[w_idx] <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stg_vld  <= 1'b0;
      r_stg_data <= 8'h00;
      r_stg_we   <= 1'b0;
      r_stg_err  <= 1'b0;
    end else begin
      r_stg_vld <= w_accept;
      if (w_accept) begin
        r_stg_data <= w_rsp_data;
        r_stg_we   <= bus.req_we;
        r_stg_err  <= !w_in_range;
      end
    end
  end

  // The occupancy limit guarantees a free slot whenever the stage is full,
  // so the stage always drains into the buffer on the next edge.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_data[r_wr_ptr] <= r_stg_data;
      r_buf_we[r_wr_ptr]   <= r_stg_we;
      r_buf_err[r_wr_ptr]  <= r_stg_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= 8'h00;
    end else if (w_pop && r_buf_err[r_rd_ptr] && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = w_rsp_valid ? r_buf_data[r_rd_ptr] : 8'h00;
  assign bus.rsp_we    = w_rsp_valid ? r_buf_we[r_rd_ptr]   : 1'b0;
  assign bus.rsp_err   = w_rsp_valid ? r_buf_err[r_rd_ptr]  : 1'b0;
  assign err_count     = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder against a queue-based
//               behavioural model; directed scenarios plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int DEPTH      = 16;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wd;
  } req_t;

  typedef struct packed {
    logic [7:0] d;
    logic       we;
    logic       err;
    int         avail;
  } rsp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] err_count;

  mem_responder_if bus();

  mem_responder #(.DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: every accepted-but-unpopped request is one queue entry; an entry
  // becomes visible in the cycle after the edge following its acceptance.
  rsp_t       mq[$];
  logic [7:0] mmem [DEPTH];
  logic [7:0] m_err   = 8'h00;
  logic       m_run   = 1'b0;
  int         cyc     = 0;
  int         m_total = 0;
  logic       do_pop, do_acc, in_rng;
  rsp_t       m_e;

  req_t       pend[$];
  logic [9:0] got[$];
  int         n_acc    = 0;
  int         rsp_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 1'b0;
      m_err = 8'h00;
      mq.delete();
      foreach (mmem[i]) mmem[i] = 8'h00;
    end else begin
      do_pop = (mq.size() > 0) && (mq[0].avail <= cyc) && bus.rsp_ready;
      do_acc = m_run && (mq.size() < FIFO_DEPTH) && bus.req_valid;
      cyc++;
      if (do_pop) begin
        if (mq[0].err && m_err != 8'hFF) m_err++;
        void'(mq.pop_front());
      end
      if (do_acc) begin
        in_rng    = int'(bus.req_addr) < DEPTH;
        m_e.we    = bus.req_we;
        m_e.err   = !in_rng;
        m_e.avail = cyc + 1;
        m_e.d     = !in_rng ? 8'h00 : (bus.req_we ? bus.req_wdata : mmem[bus.req_addr]);
        if (in_rng && bus.req_we) mmem[bus.req_addr] = bus.req_wdata;
        mq.push_back(m_e);
        m_total++;
      end
      m_run = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_rsp_we",    bus.rsp_we,    0);
      chk("rst_rsp_err",   bus.rsp_err,   0);
      chk("rst_err_count", err_count,     0);
    end else begin
      chk("req_ready", bus.req_ready, m_run && (mq.size() < FIFO_DEPTH));
      chk("rsp_valid", bus.rsp_valid, (mq.size() > 0) && (mq[0].avail <= cyc));
      if ((mq.size() > 0) && (mq[0].avail <= cyc)) begin
        chk("rsp_rdata", bus.rsp_rdata, mq[0].d);
        chk("rsp_we",    bus.rsp_we,    mq[0].we);
        chk("rsp_err",   bus.rsp_err,   mq[0].err);
      end
      chk("err_count", err_count, m_err);
      if (bus.rsp_valid && bus.rsp_ready) got.push_back({bus.rsp_we, bus.rsp_err, bus.rsp_rdata});
    end
  end

  task automatic drive_head();
    if (pend.size() > 0) begin
      bus.req_valid = 1'b1;
      bus.req_we    = pend[0].we;
      bus.req_addr  = pend[0].addr;
      bus.req_wdata = pend[0].wd;
    end else begin
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic set_mode(input int m);
    rsp_mode      = m;
    bus.rsp_ready = (m == 2) ? 1'($urandom_range(0, 1)) : (m == 1);
  endtask

  task automatic push_req(input logic we, input logic [4:0] addr, input logic [7:0] wd);
    req_t r;
    r.we = we; r.addr = addr; r.wd = wd;
    pend.push_back(r);
  endtask

  // Advance one clock; called at posedge+1 or later in the cycle.
  task automatic step();
    logic acc;
    acc = bus.req_valid && bus.req_ready;
    @(posedge clk); #1;
    if (acc) begin
      void'(pend.pop_front());
      n_acc++;
    end
    drive_head();
    set_mode(rsp_mode);
  endtask

  task automatic drain();
    int n = 0;
    while ((pend.size() > 0 || mq.size() > 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", pend.size() + mq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int a0, ns, t0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", bus.req_ready, 1);

    // Read addr 3 after reset: valid two cycles after presentation
    set_mode(1);
    got.delete();
    push_req(1'b0, 5'd3, 8'h00);
    drive_head();
    @(negedge clk);
    chk("lat_c0_valid", bus.rsp_valid, 0);
    step();
    @(negedge clk);
    chk("lat_c1_valid", bus.rsp_valid, 0);
    step();
    @(negedge clk);
    chk("lat_c2_valid", bus.rsp_valid, 1);
    chk("lat_c2_rdata", bus.rsp_rdata, 8'h00);
    chk("lat_c2_err",   bus.rsp_err,   0);
    drain();

    // Write then immediate read-back
    got.delete();
    push_req(1'b1, 5'd5, 8'hA5);
    push_req(1'b0, 5'd5, 8'h00);
    drive_head();
    drain();
    chk("wr_rd_count", got.size(), 2);
    chk("wr_rsp",      got[0], 10'h2A5);
    chk("rd_rsp",      got[1], 10'h0A5);

    // Back-pressure: six reads against a stalled consumer
    got.delete();
    set_mode(0);
    a0 = n_acc;
    for (int i = 0; i < 6; i++) push_req(1'b0, (i % 2 == 0) ? 5'd5 : 5'd0, 8'h00);
    drive_head();
    repeat (8) step();
    chk("full_accepted",  n_acc - a0, 4);
    chk("full_req_ready", bus.req_ready, 0);
    chk("full_no_pops",   got.size(), 0);
    set_mode(1);
    drain();
    chk("full_all_accepted", n_acc - a0, 6);
    chk("full_rsp_count",    got.size(), 6);
    for (int i = 0; i < 6; i++) chk("full_rsp_order", got[i], (i % 2 == 0) ? 10'h0A5 : 10'h000);

    // Out-of-range read and write, then check addr 0 was not aliased
    got.delete();
    push_req(1'b0, 5'd20, 8'h00);
    push_req(1'b1, 5'd16, 8'h55);
    push_req(1'b0, 5'd0,  8'h00);
    drive_head();
    drain();
    chk("oor_rd",    got[0], 10'h100);
    chk("oor_wr",    got[1], 10'h300);
    chk("oor_alias", got[2], 10'h000);
    chk("oor_errs",  err_count, 8'd2);

    // Asynchronous reset with three responses buffered
    push_req(1'b1, 5'd7, 8'h77);
    drive_head();
    drain();
    set_mode(0);
    push_req(1'b0, 5'd7, 8'h00);
    push_req(1'b0, 5'd5, 8'h00);
    push_req(1'b0, 5'd3, 8'h00);
    drive_head();
    repeat (5) step();
    chk("pre_rst_valid", bus.rsp_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_req_ready", bus.req_ready, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_rsp_rdata", bus.rsp_rdata, 0);
    chk("arst_rsp_we",    bus.rsp_we,    0);
    chk("arst_rsp_err",   bus.rsp_err,   0);
    chk("arst_err_count", err_count,     0);
    ns = got.size();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_arst", bus.req_ready, 1);
    pend.delete();
    drive_head();
    set_mode(1);
    repeat (5) step();
    chk("no_stale_rsp", got.size(), ns);
    push_req(1'b0, 5'd7, 8'h00);
    push_req(1'b0, 5'd5, 8'h00);
    drive_head();
    drain();
    chk("cleared_7", got[ns],     10'h000);
    chk("cleared_5", got[ns + 1], 10'h000);

    // Random traffic with random consumer stalls
    set_mode(2);
    t0 = m_total;
    for (int i = 0; i < 20; i++) begin
      push_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 23)), 8'($urandom));
    end
    drive_head();
    drain();
    chk("wrap_count", ((m_total - t0) / FIFO_DEPTH) >= 3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
